// File: rtl/tsro_pkg.sv
// Shared defaults, word layout and read-FSM encoding for the timestamp readout controller.
package tsro_pkg;

  localparam int TSRO_NREQ_DEF = 4;
  localparam int TSRO_TSW_DEF  = 16;

  function automatic int tsro_chw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int TSRO_CHW_DEF = tsro_chw(TSRO_NREQ_DEF);
  localparam int TSRO_WW_DEF  = TSRO_CHW_DEF + TSRO_TSW_DEF;

  typedef struct packed {
    logic [TSRO_CHW_DEF-1:0] ch;
    logic [TSRO_TSW_DEF-1:0] ts;
  } tsro_word_t;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_FETCH   = 2'd1,
    RD_PRESENT = 2'd2
  } tsro_rd_state_e;

endpackage

// File: rtl/tstamp_readout_ctrl_if.sv
// Buffer write/read bus plus readout handshake; master = controller, slave = buffer/consumer side.
interface tstamp_readout_ctrl_if import tsro_pkg::*; #(parameter int WW = TSRO_WW_DEF);

  logic          fifo_full_i;
  logic          fifo_empty_i;
  logic          fifo_we_o;
  logic [WW-1:0] fifo_wdata_o;
  logic          fifo_re_o;
  logic [WW-1:0] fifo_rdata_i;
  logic [WW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;

  modport master (
    input  fifo_full_i, fifo_empty_i, fifo_rdata_i, out_ready_i,
    output fifo_we_o, fifo_wdata_o, fifo_re_o, out_data_o, out_valid_o
  );

  modport slave (
    output fifo_full_i, fifo_empty_i, fifo_rdata_i, out_ready_i,
    input  fifo_we_o, fifo_wdata_o, fifo_re_o, out_data_o, out_valid_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the index after the last grant; grants only while advance_i is high.
module rr_arbiter import tsro_pkg::*; #(
  parameter int N = TSRO_NREQ_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = tsro_chw(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && advance_i && req_i[idx[PW-1:0]]) begin
        found                 = 1'b1;
        grant_o[idx[PW-1:0]]  = 1'b1;
        ptr_d                 = (idx + 1 >= N) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tstamp_readout_ctrl.sv
// Per-channel hit timestamp capture, round-robin write into a buffer, and a fetch/present readout FSM.
// Optional TSRO_DROP_CNT_EN adds drop_cnt_o: per-channel saturating 8-bit lost-hit counters.
module tstamp_readout_ctrl import tsro_pkg::*; #(
  parameter int NREQ   = TSRO_NREQ_DEF,
  parameter int TSW    = TSRO_TSW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [NREQ-1:0]      hit_i,
  input  logic [TSW-1:0]       tstamp_i,
  tstamp_readout_ctrl_if.master bus,
  output logic [NREQ-1:0]      drop_o
`ifdef TSRO_DROP_CNT_EN
  ,
  output logic [NREQ-1:0][7:0] drop_cnt_o
`endif
);

  localparam int CHW = tsro_chw(NREQ);
  localparam int WW  = CHW + TSW;

  localparam logic [1:0] ST_IDLE    = RD_IDLE;
  localparam logic [1:0] ST_FETCH   = RD_FETCH;
  localparam logic [1:0] ST_PRESENT = RD_PRESENT;
  localparam logic [1:0] LAT_LAST   = 2'(RD_LAT - 1);

  logic [NREQ-1:0]          hit_prev_q;
  logic [NREQ-1:0]          rise;
  logic [NREQ-1:0]          pending;
  logic [NREQ-1:0]          grant;
  logic [NREQ-1:0][TSW-1:0] ts_all;

  assign rise = hit_i & ~hit_prev_q & {NREQ{en_i}};

  always_ff @(posedge clk) begin
    if (rst) hit_prev_q <= '0;
    else     hit_prev_q <= hit_i;
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (pending),
    .advance_i (~bus.fifo_full_i),
    .grant_o   (grant)
  );

  // A hit on the channel being granted reloads it; otherwise a hit on a busy channel is lost.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_chan
    logic           pend_q;
    logic [TSW-1:0] ts_q;
    logic           drop_q;
    logic           lost;

    assign lost = rise[gi] & pend_q & ~grant[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        pend_q <= 1'b0;
        ts_q   <= '0;
        drop_q <= 1'b0;
      end else if (lost) begin
        drop_q <= 1'b1;
      end else if (rise[gi]) begin
        ts_q   <= tstamp_i;
        pend_q <= 1'b1;
      end else if (grant[gi]) begin
        pend_q <= 1'b0;
      end
    end

    assign pending[gi] = pend_q;
    assign ts_all[gi]  = ts_q;
    assign drop_o[gi]  = drop_q;

`ifdef TSRO_DROP_CNT_EN
    logic [7:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst)                          cnt_q <= '0;
      else if (lost && cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
    end
    assign drop_cnt_o[gi] = cnt_q;
`endif
  end

  logic [CHW-1:0] wsel_ch;
  logic [TSW-1:0] wsel_ts;

  always_comb begin
    wsel_ch = '0;
    wsel_ts = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        wsel_ch = CHW'(i);
        wsel_ts = ts_all[i];
      end
    end
  end

  assign bus.fifo_we_o    = |grant;
  assign bus.fifo_wdata_o = {wsel_ch, wsel_ts};

  logic [1:0]    state_q, state_d;
  logic [1:0]    lat_q, lat_d;
  logic [WW-1:0] odata_q, odata_d;
  logic          ovalid_q, ovalid_d;
  logic          rd_req;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    rd_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.fifo_empty_i && !ovalid_q) begin
          rd_req  = 1'b1;
          lat_d   = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (lat_q == LAT_LAST) begin
          odata_d  = bus.fifo_rdata_i;
          ovalid_d = 1'b1;
          state_d  = ST_PRESENT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_PRESENT: begin
        if (bus.out_ready_i) begin
          ovalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        ovalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign bus.fifo_re_o   = rd_req;
  assign bus.out_data_o  = odata_q;
  assign bus.out_valid_o = ovalid_q;

endmodule

// File: tb/tb_tstamp_readout_ctrl.sv
// Randomized and directed bench for tstamp_readout_ctrl against a transaction-level reference model.
module tb_tstamp_readout_ctrl;
  import tsro_pkg::*;

  localparam int NREQ   = 4;
  localparam int TSW    = 16;
  localparam int RD_LAT = 2;
  localparam int CHW    = 2;
  localparam int WW     = CHW + TSW;
  localparam int DEPTH  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en_i = 1'b0;
  logic [NREQ-1:0] hit_i = '0;
  logic [TSW-1:0]  tstamp_i = '0;
  logic [NREQ-1:0] drop_o;
`ifdef TSRO_DROP_CNT_EN
  logic [NREQ-1:0][7:0] drop_cnt;
`endif

  tstamp_readout_ctrl_if #(.WW(WW)) bus ();

  tstamp_readout_ctrl #(.NREQ(NREQ), .TSW(TSW), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .hit_i    (hit_i),
    .tstamp_i (tstamp_i),
    .bus      (bus),
    .drop_o   (drop_o)
`ifdef TSRO_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Buffer model: plain queue with RD_LAT-cycle read pipeline.
  logic [WW-1:0] fifo_q[$];
  int            fcnt = 0;
  logic          force_full = 1'b0;
  logic [WW-1:0] rd_pipe [RD_LAT];

  assign bus.fifo_full_i  = force_full | (fcnt >= DEPTH);
  assign bus.fifo_empty_i = (fcnt == 0);
  assign bus.fifo_rdata_i = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fcnt <= 0;
    end else begin
      if (bus.fifo_re_o && fifo_q.size() > 0) rd_pipe[0] <= fifo_q.pop_front();
      if (bus.fifo_we_o) fifo_q.push_back(bus.fifo_wdata_o);
      fcnt <= fifo_q.size();
    end
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Reference model state
  logic [NREQ-1:0] m_pend, m_drop, m_prev;
  logic [TSW-1:0]  m_ts [NREQ];
  int              m_dcnt [NREQ];
  int              m_ptr;
  int              m_rdcnt;
  logic            m_present;
  logic [WW-1:0]   m_word, m_fetch_word;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] mkw(input int ch, input logic [TSW-1:0] ts);
    tsro_word_t w;
    w.ch = CHW'(ch);
    w.ts = ts;
    return w;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_drop = '0; m_prev = '0;
    for (int n = 0; n < NREQ; n++) begin
      m_ts[n] = '0;
      m_dcnt[n] = 0;
    end
    m_ptr = 0; m_rdcnt = 0; m_present = 1'b0;
    m_word = '0; m_fetch_word = '0;
  endtask

  // One clock cycle: drive inputs at negedge, compare against the model, then advance the model.
  task automatic step(input logic [NREQ-1:0] hit, input logic en, input logic [TSW-1:0] ts,
                      input logic full, input logic ready, input logic r);
    int   g;
    int   idx;
    logic exp_re;
    logic rise;
    @(negedge clk);
    hit_i = hit; en_i = en; tstamp_i = ts; force_full = full; bus.out_ready_i = ready; rst = r;
    #1;
    g = -1;
    if (!(full || fcnt >= DEPTH)) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && m_pend[idx]) g = idx;
      end
    end
    exp_re = !m_present && (m_rdcnt == 0) && (fcnt > 0);
    chk("we", 64'(bus.fifo_we_o), 64'(g >= 0));
    if (g >= 0) chk("wdata", 64'(bus.fifo_wdata_o), 64'(mkw(g, m_ts[g])));
    chk("drop", 64'(drop_o), 64'(m_drop));
    chk("re", 64'(bus.fifo_re_o), 64'(exp_re));
    chk("valid", 64'(bus.out_valid_o), 64'(m_present));
    chk("odata", 64'(bus.out_data_o), 64'(m_word));
`ifdef TSRO_DROP_CNT_EN
    for (int n = 0; n < NREQ; n++) chk($sformatf("dcnt%0d", n), 64'(drop_cnt[n]), 64'(m_dcnt[n]));
`endif
    if (r) begin
      model_reset();
    end else begin
      for (int n = 0; n < NREQ; n++) begin
        rise = en && hit[n] && !m_prev[n];
        if (rise && m_pend[n] && g != n) begin
          m_drop[n] = 1'b1;
          if (m_dcnt[n] < 255) m_dcnt[n]++;
        end else if (rise) begin
          m_ts[n] = ts;
          m_pend[n] = 1'b1;
        end else if (g == n) begin
          m_pend[n] = 1'b0;
        end
      end
      if (g >= 0) m_ptr = (g + 1) % NREQ;
      m_prev = hit;
      if (exp_re) begin
        m_fetch_word = fifo_q[0];
        m_rdcnt = RD_LAT;
      end else if (m_rdcnt > 0) begin
        m_rdcnt--;
        if (m_rdcnt == 0) begin
          m_present = 1'b1;
          m_word = m_fetch_word;
        end
      end else if (m_present && ready) begin
        m_present = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    repeat (2) step('0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wait_valid(input string tag, input logic ready);
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid_o) break;
      step(hit_i, 1'b1, tstamp_i + 16'd1, 1'b0, ready, 1'b0);
    end
    chk(tag, 64'(bus.out_valid_o), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] hv;
    logic [TSW-1:0]  tsv;
    model_reset();
    bus.out_ready_i = 1'b0;
    do_reset();

    // Reset state
    step('0, 1'b1, 16'h000F, 1'b0, 1'b1, 1'b0);
    chk("rst_we", 64'(bus.fifo_we_o), 64'd0);
    chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);

    // Single hit on ch2
    step(4'b0100, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b0);
    chk("t1_we", 64'(bus.fifo_we_o), 64'd1);
    chk("t1_wdata", 64'(bus.fifo_wdata_o), 64'(mkw(2, 16'h0010)));
    wait_valid("t1_valid", 1'b1);
    chk("t1_out", 64'(bus.out_data_o), 64'(mkw(2, 16'h0010)));

    // Simultaneous hits 1011
    do_reset();
    step('0, 1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0);
    step(4'b1011, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b0);
    step(4'b1011, 1'b1, 16'h0101, 1'b0, 1'b1, 1'b0);
    chk("t2_w0", 64'(bus.fifo_wdata_o), 64'(mkw(0, 16'h0100)));
    step(4'b1011, 1'b1, 16'h0102, 1'b0, 1'b1, 1'b0);
    chk("t2_w1", 64'(bus.fifo_wdata_o), 64'(mkw(1, 16'h0100)));
    step(4'b1011, 1'b1, 16'h0103, 1'b0, 1'b1, 1'b0);
    chk("t2_w3", 64'(bus.fifo_wdata_o), 64'(mkw(3, 16'h0100)));
    chk("t2_we", 64'(bus.fifo_we_o), 64'd1);
    repeat (20) step(4'b1011, 1'b1, 16'h0104, 1'b0, 1'b1, 1'b0);

    // Full stall with a second ch1 hit
    do_reset();
    step('0, 1'b1, 16'h01FF, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 16'h0200, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 16'h0201, 1'b1, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 16'h0210, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 16'h0211, 1'b1, 1'b0, 1'b0);
    chk("t3_we_full", 64'(bus.fifo_we_o), 64'd0);
    chk("t3_drop", 64'(drop_o), 64'(4'b0010));
    step(4'b0000, 1'b1, 16'h0212, 1'b0, 1'b0, 1'b0);
    chk("t3_we", 64'(bus.fifo_we_o), 64'd1);
    chk("t3_wdata", 64'(bus.fifo_wdata_o), 64'(mkw(1, 16'h0200)));

    // Backpressure in PRESENT
    wait_valid("t4_valid", 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 1'b1, 16'h0220, 1'b0, 1'b0, 1'b0);
      chk("t4_hold_valid", 64'(bus.out_valid_o), 64'd1);
      chk("t4_no_re", 64'(bus.fifo_re_o), 64'd0);
      chk("t4_hold_data", 64'(bus.out_data_o), 64'(mkw(1, 16'h0200)));
    end
    step(4'b0000, 1'b1, 16'h0221, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 16'h0222, 1'b0, 1'b0, 1'b0);
    chk("t4_idle", 64'(bus.out_valid_o), 64'd0);

    // Reset during FETCH
    do_reset();
    step('0, 1'b1, 16'h02FF, 1'b0, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 16'h0300, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (bus.fifo_re_o) break;
      step(4'b1000, 1'b1, 16'h0301, 1'b0, 1'b1, 1'b0);
    end
    chk("t5_re", 64'(bus.fifo_re_o), 64'd1);
    step(4'b1000, 1'b1, 16'h0302, 1'b0, 1'b1, 1'b1);
    step(4'b1000, 1'b1, 16'h0400, 1'b0, 1'b1, 1'b0);
    chk("t5_we", 64'(bus.fifo_we_o), 64'd0);
    chk("t5_re0", 64'(bus.fifo_re_o), 64'd0);
    chk("t5_valid", 64'(bus.out_valid_o), 64'd0);
    chk("t5_data", 64'(bus.out_data_o), 64'd0);
    chk("t5_drop", 64'(drop_o), 64'd0);
    repeat (12) step(4'b1000, 1'b1, 16'h0401, 1'b0, 1'b1, 1'b0);

`ifdef TSRO_DROP_CNT_EN
    // 300 lost ch0 hits saturate the counter
    do_reset();
    step('0, 1'b1, 16'h0500, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 301; i++) begin
      step(4'b0001, 1'b1, 16'(16'h0600 + i), 1'b1, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 16'(16'h0600 + i), 1'b1, 1'b1, 1'b0);
    end
    chk("t6_dcnt0", 64'(drop_cnt[0]), 64'd255);
`endif

    // Randomized traffic
    do_reset();
    hv = '0;
    tsv = 16'(16'hFFF0);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 1) == 0) hv = NREQ'($urandom);
      tsv = tsv + 16'd1;
      step(hv, ($urandom_range(0, 9) != 0), tsv, ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) < 3), ($urandom_range(0, 499) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tstamp_readout_ctrl.md
TSTAMP_READOUT_CTRL -- requirements
Module: tstamp_readout_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of hit requesters.
REQ-002 SHALL have parameter TSW, default 16: timestamp width.
REQ-003 SHALL have parameter RD_LAT, default 1: cycles from fifo_re_o to valid fifo_data_i, range 1..3.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port en_i  in  1  capture enable; 0 ignores new hits.
REQ-007 SHALL have port hit_i  in  NREQ  per-requester hit level, synchronous to clk.
REQ-008 SHALL have port tstamp_i  in  TSW  free-running timestamp counter value.
REQ-009 SHALL have port fifo_full_i  in  1  timestamp buffer full.
REQ-010 SHALL have port fifo_empty_i  in  1  timestamp buffer empty.
REQ-011 SHALL have port fifo_we_o  out  1  buffer write strobe.
REQ-012 SHALL have port fifo_wdata_o  out  CHW+TSW  {channel, timestamp}; CHW=clog2(NREQ).
REQ-013 SHALL have port fifo_re_o  out  1  buffer read strobe.
REQ-014 SHALL have port fifo_rdata_i  in  CHW+TSW  buffer read data.
REQ-015 SHALL have port out_data_o  out  CHW+TSW  readout word.
REQ-016 SHALL have port out_valid_o / out_ready_i  out/in  1  readout handshake.
REQ-017 SHALL have port drop_o  out  NREQ  sticky per-channel hit-lost flag.

Function
REQ-018 SHALL detect a hit as a 0->1 transition of hit_i[n] between consecutive cycles while en_i=1.
REQ-019 SHALL latch tstamp_i into channel n's pending register on the hit cycle and set pending[n].
REQ-020 SHALL, when a hit occurs while pending[n]=1 and that channel is not granted this cycle, keep the old timestamp and set drop_o[n].
REQ-021 SHALL grant at most one pending channel per cycle, and only when fifo_full_i=0, using round-robin starting after the last granted index.
REQ-022 SHALL, on grant of n, assert fifo_we_o for exactly that cycle with fifo_wdata_o={n, ts[n]}, and clear pending[n].
REQ-023 SHALL, on a hit to the channel being granted in the same cycle, write the old timestamp and reload pending[n] with the new one; no drop.
REQ-024 SHALL implement read FSM states IDLE, FETCH, PRESENT.
REQ-025 SHALL move IDLE->FETCH with fifo_re_o high for one cycle when fifo_empty_i=0 and out_valid_o=0.
REQ-026 SHALL remain in FETCH for RD_LAT cycles, capture fifo_rdata_i into out_data_o, then enter PRESENT with out_valid_o=1.
REQ-027 SHALL hold out_data_o stable in PRESENT until out_valid_o&out_ready_i, then return to IDLE; back-to-back reads need one IDLE cycle.
REQ-028 SHALL never assert fifo_we_o while fifo_full_i=1, nor fifo_re_o while fifo_empty_i=1.
REQ-029 SHALL ignore tstamp_i wrap-around; timestamps are stored raw, with no ordering correction.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear pending, drop_o, fifo_we_o, fifo_re_o, out_valid_o, and out_data_o to 0; FSM to IDLE; round-robin pointer to channel 0; edge-detect history to 0.
REQ-031 SHALL abort an in-flight FETCH/PRESENT on reset; the word is lost.

Configuration
REQ-032 SHALL, with TSRO_DROP_CNT_EN defined, add output drop_cnt_o (NREQ x 8) holding per-channel saturating counts of lost hits, cleared by reset, stuck at 255.
REQ-033 SHALL, without TSRO_DROP_CNT_EN, omit drop_cnt_o and its counters; drop_o behaviour is unchanged.

Structure
REQ-034 SHALL take NREQ/TSW defaults, CHW, the word type and the read-FSM state enum from shared package tsro_pkg.
REQ-035 SHALL place the round-robin arbiter in sub-module rr_arbiter (req, grant one-hot, advance strobe).

Verification
REQ-036 SHALL cover single hit: hit_i[2] rises at tstamp 0x0010 -> next cycle fifo_we_o=1, wdata={2,0x0010}, then readout word {2,0x0010}.
REQ-037 SHALL cover simultaneous hits: hit_i=4'b1011 at 0x0100, fifo never full -> writes in order ch0, ch1, ch3 on three consecutive cycles.
REQ-038 SHALL cover full stall: fifo_full_i=1 with ch1 pending and a second ch1 hit -> no write, drop_o[1]=1, first timestamp written after full deasserts.
REQ-039 SHALL cover backpressure: out_ready_i=0 for 5 cycles in PRESENT -> out_data_o stable, no fifo_re_o; a ready pulse returns the FSM to IDLE.
REQ-040 SHALL cover mid-operation reset: rst in FETCH with RD_LAT=2 -> next cycle all outputs 0 and FSM IDLE.
REQ-041 SHALL cover the counter build: with TSRO_DROP_CNT_EN, 300 lost ch0 hits -> drop_cnt_o[0]=255.
